// File: rtl/hazard_stall_ctrl.sv
//==============================================================================
// Module      : hazard_stall_ctrl
// Description : Pipeline sequencing controller for the 5-stage MIPS core.
//               Generates PC / IF/ID / ID/EX / EX/MEM stall, flush and hold
//               controls. It inserts a one-cycle bubble on a load-use hazard,
//               flushes younger instructions on a taken branch, and freezes
//               the pipe while data memory is busy.
//               Optional macro HAZ_PERF_CNT_EN adds saturating 16-bit
//               performance counters for the load-use, flush and memory-wait
//               causes.
// Revision    : 1.0  initial release
//==============================================================================
`default_nettype none

module hazard_stall_ctrl #(
    parameter int FLUSH_CYCLES = 2,
    parameter int REG_W        = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] if_id_rs,
    input  logic [REG_W-1:0] if_id_rt,
    input  logic             if_id_uses_rt,
    input  logic [REG_W-1:0] id_ex_rt,
    input  logic             id_ex_memread,
    input  logic             branch_taken,
    input  logic             dmem_busy,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             if_id_flush,
    output logic             id_ex_bubble,
    output logic             id_ex_hold,
    output logic             ex_mem_hold,
    output logic [1:0]       ctrl_state
`ifdef HAZ_PERF_CNT_EN
    ,
    output logic [15:0]      lu_stall_cnt,
    output logic [15:0]      flush_cnt,
    output logic [15:0]      mem_wait_cnt
`endif
);

    localparam logic [1:0]       c_RUN        = 2'b00;
    localparam logic [1:0]       c_LU_STALL   = 2'b01;
    localparam logic [1:0]       c_FLUSH      = 2'b10;
    localparam logic [1:0]       c_MEM_WAIT   = 2'b11;
    localparam logic [2:0]       c_FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);
    localparam logic             c_MULTI_FLUSH = (FLUSH_CYCLES > 1);
    localparam logic [REG_W-1:0] c_ZERO_REG   = '0;

    logic [1:0] r_state;
    logic [1:0] w_next_state;
    logic [2:0] r_cnt;
    logic [2:0] w_next_cnt;

    logic w_lu;
    logic w_run_eval;
    logic w_freeze_evt;
    logic w_flush_evt;
    logic w_lu_evt;

    // Event decode shared by the next-state and output logic. dmem_busy
    // always wins; RUN, LU_STALL and an unfrozen MEM_WAIT use the same
    // evaluation, with load-use masked only in LU_STALL.
    always_comb begin
        w_lu = id_ex_memread && (id_ex_rt != c_ZERO_REG) &&
               ((id_ex_rt == if_id_rs) || (if_id_uses_rt && (id_ex_rt == if_id_rt)));
        w_run_eval   = (r_state != c_FLUSH);
        w_freeze_evt = dmem_busy;
        w_flush_evt  = !dmem_busy && ((w_run_eval && branch_taken) || (r_state == c_FLUSH));
        w_lu_evt     = !dmem_busy && w_run_eval && !branch_taken && w_lu &&
                       (r_state != c_LU_STALL);
    end

    // State and flush-counter register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= c_RUN;
            r_cnt   <= 3'd0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
        end
    end

    // Next-state logic. A freeze abandons any flush in progress because the
    // bubbles already issued cover the squashed instructions.
    always_comb begin
        w_next_state = c_RUN;
        w_next_cnt   = 3'd0;
        if (dmem_busy) begin
            w_next_state = c_MEM_WAIT;
        end else if (r_state == c_FLUSH) begin
            if (r_cnt > 3'd1) begin
                w_next_state = c_FLUSH;
                w_next_cnt   = r_cnt - 3'd1;
            end
        end else if (branch_taken) begin
            if (c_MULTI_FLUSH) begin
                w_next_state = c_FLUSH;
                w_next_cnt   = c_FLUSH_LOAD;
            end
        end else if (w_lu_evt) begin
            w_next_state = c_LU_STALL;
        end
    end

    // Output logic: combinational from state and current inputs so a stall
    // acts in the same cycle the hazard is visible.
    always_comb begin
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        id_ex_hold   = 1'b0;
        ex_mem_hold  = 1'b0;
        ctrl_state   = r_state;
        if (!rst) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
            ctrl_state   = c_RUN;
        end else if (w_freeze_evt) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_hold   = 1'b1;
            ex_mem_hold  = 1'b1;
        end else if (w_flush_evt) begin
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
        end else if (w_lu_evt) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
        end
    end

`ifdef HAZ_PERF_CNT_EN
    logic [15:0] r_lu_stall_cnt;
    logic [15:0] r_flush_cnt;
    logic [15:0] r_mem_wait_cnt;

    // Saturating per-cause cycle counters.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_lu_stall_cnt <= 16'd0;
            r_flush_cnt    <= 16'd0;
            r_mem_wait_cnt <= 16'd0;
        end else begin
            if (w_lu_evt && (r_lu_stall_cnt != 16'hFFFF))
                r_lu_stall_cnt <= r_lu_stall_cnt + 16'd1;
            if (w_flush_evt && (r_flush_cnt != 16'hFFFF))
                r_flush_cnt <= r_flush_cnt + 16'd1;
            if (w_freeze_evt && (r_mem_wait_cnt != 16'hFFFF))
                r_mem_wait_cnt <= r_mem_wait_cnt + 16'd1;
        end
    end

    assign lu_stall_cnt = r_lu_stall_cnt;
    assign flush_cnt    = r_flush_cnt;
    assign mem_wait_cnt = r_mem_wait_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_hazard_stall_ctrl.sv
//==============================================================================
// Module      : tb_hazard_stall_ctrl
// Description : Scoreboard bench for hazard_stall_ctrl (FLUSH_CYCLES=2).
//               Expected output vectors are hand-derived constants pushed
//               when stimulus is applied and popped when outputs are sampled.
//               Vector: {pc_write, if_id_write, if_id_flush, id_ex_bubble,
//                        id_ex_hold, ex_mem_hold, ctrl_state[1:0]}
// Revision    : 1.0  initial release
//==============================================================================
`default_nettype none

module tb_hazard_stall_ctrl;

    localparam logic [7:0] c_DEF   = 8'b1100_0000;
    localparam logic [7:0] c_LU    = 8'b0001_0000;
    localparam logic [7:0] c_LUS   = 8'b1100_0001;
    localparam logic [7:0] c_BR    = 8'b1111_0000;
    localparam logic [7:0] c_FL    = 8'b1111_0010;
    localparam logic [7:0] c_FRZ0  = 8'b0000_1100;
    localparam logic [7:0] c_FRZ2  = 8'b0000_1110;
    localparam logic [7:0] c_FRZ3  = 8'b0000_1111;
    localparam logic [7:0] c_BR3   = 8'b1111_0011;
    localparam logic [7:0] c_DEF3  = 8'b1100_0011;
    localparam logic [7:0] c_RST   = 8'b0011_0000;

    typedef struct packed {
        logic       r;
        logic       br;
        logic       busy;
        logic       mr;
        logic       ur;
        logic [3:0] exrt;
        logic [3:0] rs;
        logic [3:0] rt;
        logic [7:0] exp;
    } vec_t;

    logic       clk;
    logic       rst;
    logic [3:0] if_id_rs;
    logic [3:0] if_id_rt;
    logic       if_id_uses_rt;
    logic [3:0] id_ex_rt;
    logic       id_ex_memread;
    logic       branch_taken;
    logic       dmem_busy;
    logic       pc_write;
    logic       if_id_write;
    logic       if_id_flush;
    logic       id_ex_bubble;
    logic       id_ex_hold;
    logic       ex_mem_hold;
    logic [1:0] ctrl_state;
`ifdef HAZ_PERF_CNT_EN
    logic [15:0] lu_stall_cnt;
    logic [15:0] flush_cnt;
    logic [15:0] mem_wait_cnt;
`endif

    int n_chk  = 0;
    int n_fail = 0;
    logic [7:0] sb [$];

    hazard_stall_ctrl #(.FLUSH_CYCLES(2), .REG_W(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .if_id_rs     (if_id_rs),
        .if_id_rt     (if_id_rt),
        .if_id_uses_rt(if_id_uses_rt),
        .id_ex_rt     (id_ex_rt),
        .id_ex_memread(id_ex_memread),
        .branch_taken (branch_taken),
        .dmem_busy    (dmem_busy),
        .pc_write     (pc_write),
        .if_id_write  (if_id_write),
        .if_id_flush  (if_id_flush),
        .id_ex_bubble (id_ex_bubble),
        .id_ex_hold   (id_ex_hold),
        .ex_mem_hold  (ex_mem_hold),
        .ctrl_state   (ctrl_state)
`ifdef HAZ_PERF_CNT_EN
        ,
        .lu_stall_cnt (lu_stall_cnt),
        .flush_cnt    (flush_cnt),
        .mem_wait_cnt (mem_wait_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic r, input logic br, input logic busy,
                                input logic mr, input logic ur, input logic [3:0] exrt,
                                input logic [3:0] rs, input logic [3:0] rt,
                                input logic [7:0] exp);
        vec_t v;
        v = {r, br, busy, mr, ur, exrt, rs, rt, exp};
        return v;
    endfunction

    // Applies one cycle of stimulus at the falling edge and records its
    // expected outputs in the scoreboard.
    task automatic apply(input vec_t v);
        @(negedge clk);
        rst           = v.r;
        branch_taken  = v.br;
        dmem_busy     = v.busy;
        id_ex_memread = v.mr;
        if_id_uses_rt = v.ur;
        id_ex_rt      = v.exrt;
        if_id_rs      = v.rs;
        if_id_rt      = v.rt;
        sb.push_back(v.exp);
        #1;
    endtask

    function automatic logic [7:0] outs();
        return {pc_write, if_id_write, if_id_flush, id_ex_bubble,
                id_ex_hold, ex_mem_hold, ctrl_state};
    endfunction

    task automatic test_reset();
        vec_t q [$];
        logic [7:0] want;
        q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, c_RST));
        q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, c_RST));
        q.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, c_DEF));
        foreach (q[i]) begin
            apply(q[i]);
            want = sb.pop_front();
            n_chk++;
            if (outs() !== want) begin
                n_fail++;
                $display("FAIL reset[%0d] got %b want %b", i, outs(), want);
            end
        end
    endtask

    task automatic test_load_use();
        vec_t q [$];
        logic [7:0] want;
        q.push_back(mk(1, 0, 0, 1, 0, 5, 5, 0, c_LU));
        q.push_back(mk(1, 0, 0, 1, 0, 5, 5, 0, c_LUS));
        q.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, c_DEF));
        q.push_back(mk(1, 0, 0, 1, 1, 7, 0, 7, c_LU));
        q.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, c_LUS));
        q.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, c_DEF));
        foreach (q[i]) begin
            apply(q[i]);
            want = sb.pop_front();
            n_chk++;
            if (outs() !== want) begin
                n_fail++;
                $display("FAIL load_use[%0d] got %b want %b", i, outs(), want);
            end
        end
    endtask

    task automatic test_qualify();
        vec_t q [$];
        logic [7:0] want;
        q.push_back(mk(1, 0, 0, 1, 0, 5, 3, 5, c_DEF));
        q.push_back(mk(1, 0, 0, 1, 1, 0, 0, 0, c_DEF));
        q.push_back(mk(1, 0, 0, 0, 1, 5, 5, 5, c_DEF));
        foreach (q[i]) begin
            apply(q[i]);
            want = sb.pop_front();
            n_chk++;
            if (outs() !== want) begin
                n_fail++;
                $display("FAIL qualify[%0d] got %b want %b", i, outs(), want);
            end
        end
    endtask

    task automatic test_branch();
        vec_t q [$];
        logic [7:0] want;
        q.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, c_BR));
        q.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, c_FL));
        q.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, c_DEF));
        q.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, c_BR));
        q.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, c_FL));
        q.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, c_DEF));
        foreach (q[i]) begin
            apply(q[i]);
            want = sb.pop_front();
            n_chk++;
            if (outs() !== want) begin
                n_fail++;
                $display("FAIL branch[%0d] got %b want %b", i, outs(), want);
            end
        end
    endtask

    task automatic test_priority();
        vec_t q [$];
        logic [7:0] want;
        q.push_back(mk(1, 1, 0, 1, 0, 5, 5, 0, c_BR));
        q.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, c_FL));
        q.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, c_DEF));
        q.push_back(mk(1, 1, 1, 0, 0, 0, 0, 0, c_FRZ0));
        q.push_back(mk(1, 1, 1, 0, 0, 0, 0, 0, c_FRZ3));
        q.push_back(mk(1, 1, 1, 0, 0, 0, 0, 0, c_FRZ3));
        q.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, c_BR3));
        q.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, c_FL));
        q.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, c_DEF));
        q.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, c_BR));
        q.push_back(mk(1, 0, 1, 0, 0, 0, 0, 0, c_FRZ2));
        q.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, c_DEF3));
        q.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, c_DEF));
        foreach (q[i]) begin
            apply(q[i]);
            want = sb.pop_front();
            n_chk++;
            if (outs() !== want) begin
                n_fail++;
                $display("FAIL priority[%0d] got %b want %b", i, outs(), want);
            end
        end
    endtask

    task automatic test_reset_mid_op();
        vec_t q [$];
        logic [7:0] want;
        q.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, c_BR));
        q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, c_RST));
        q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, c_RST));
        q.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, c_DEF));
        q.push_back(mk(1, 0, 1, 0, 0, 0, 0, 0, c_FRZ0));
        q.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, c_RST));
        q.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, c_DEF));
        foreach (q[i]) begin
            apply(q[i]);
            want = sb.pop_front();
            n_chk++;
            if (outs() !== want) begin
                n_fail++;
                $display("FAIL reset_mid_op[%0d] got %b want %b", i, outs(), want);
            end
        end
    endtask

`ifdef HAZ_PERF_CNT_EN
    task automatic test_perf_cnt();
        vec_t q [$];
        logic [47:0] got;
        q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, c_RST));
        q.push_back(mk(1, 0, 0, 1, 0, 5, 5, 0, c_LU));
        q.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, c_LUS));
        q.push_back(mk(1, 0, 0, 1, 0, 6, 6, 0, c_LU));
        q.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, c_LUS));
        q.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, c_BR));
        q.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, c_FL));
        q.push_back(mk(1, 0, 1, 0, 0, 0, 0, 0, c_FRZ0));
        q.push_back(mk(1, 0, 1, 0, 0, 0, 0, 0, c_FRZ3));
        q.push_back(mk(1, 0, 1, 0, 0, 0, 0, 0, c_FRZ3));
        q.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, c_DEF3));
        foreach (q[i]) begin
            apply(q[i]);
            void'(sb.pop_front());
        end
        got = {lu_stall_cnt, flush_cnt, mem_wait_cnt};
        n_chk++;
        if (got !== {16'd2, 16'd2, 16'd3}) begin
            n_fail++;
            $display("FAIL perf_cnt got lu=%0d fl=%0d mw=%0d want lu=2 fl=2 mw=3",
                     lu_stall_cnt, flush_cnt, mem_wait_cnt);
        end
    endtask
`endif

    initial begin
        rst           = 1'b0;
        branch_taken  = 1'b0;
        dmem_busy     = 1'b0;
        id_ex_memread = 1'b0;
        if_id_uses_rt = 1'b0;
        id_ex_rt      = 4'd0;
        if_id_rs      = 4'd0;
        if_id_rt      = 4'd0;
        test_reset();
        test_load_use();
        test_qualify();
        test_branch();
        test_priority();
        test_reset_mid_op();
`ifdef HAZ_PERF_CNT_EN
        test_perf_cnt();
`endif
        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
- Pipeline sequencing controller for the 5-stage MIPS core; owns the stall/flush/hold controls around IF/ID and ID/EX.
- Detects load-use hazards and injects one bubble into ID/EX.
- Flushes younger instructions when a branch resolves taken in EX.
- Freezes the whole pipe while data memory reports busy.

Parameters:
- FLUSH_CYCLES, 2, number of cycles if_id_flush/id_ex_bubble stay asserted after a taken branch; legal range 1..7.
- REG_W, 4, register-specifier width; matches the pipeline Rs/Rt/Rd fields.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-low (rst=0 resets on the next rising clk edge).
- if_id_rs  in  REG_W  Rs of the instruction in ID.
- if_id_rt  in  REG_W  Rt of the instruction in ID.
- if_id_uses_rt  in  1  Rt is a source operand (R-type, beq, sw).
- id_ex_rt  in  REG_W  Rt of the instruction in EX.
- id_ex_memread  in  1  MemRead of the instruction in EX.
- branch_taken  in  1  branch resolved taken in EX; EX holds it stable while frozen.
- dmem_busy  in  1  data memory not ready this cycle.
- pc_write  out  1  PC load enable.
- if_id_write  out  1  IF/ID load enable.
- if_id_flush  out  1  IF/ID clears to NOP.
- id_ex_bubble  out  1  zeroes ID/EX control fields (MemRead, MemtoReg, MemWrite, ALUSrc, RegWrite, ALUop).
- id_ex_hold  out  1  ID/EX keeps its contents.
- ex_mem_hold  out  1  EX/MEM keeps its contents.
- ctrl_state  out  2  current FSM state, for debug.

Behaviour:
- FSM states: RUN=00, LU_STALL=01, FLUSH=10, MEM_WAIT=11.
- State and a 3-bit flush counter are registered. Outputs are combinational from state plus current inputs, so a stall takes effect in the cycle the hazard is visible.
- Default outputs: pc_write=1, if_id_write=1, all others 0.
- Load-use hazard (lu): id_ex_memread && id_ex_rt!=0 && (id_ex_rt==if_id_rs || (if_id_uses_rt && id_ex_rt==if_id_rt)).
- Event priority each cycle: dmem_busy > branch_taken > lu.
- RUN:
  - dmem_busy: pc_write=0, if_id_write=0, id_ex_hold=1, ex_mem_hold=1; next MEM_WAIT.
  - branch_taken: if_id_flush=1, id_ex_bubble=1, PC loads the target. If FLUSH_CYCLES>1, next FLUSH with cnt=FLUSH_CYCLES-1; else stay RUN.
  - lu: pc_write=0, if_id_write=0, id_ex_bubble=1; next LU_STALL.
  - otherwise stay RUN.
- LU_STALL (exactly 1 cycle): lu detection masked; default outputs; dmem_busy and branch_taken are handled exactly as in RUN; otherwise next RUN. Consecutive load-use stalls are therefore separated by at least one issuing cycle.
- FLUSH: if_id_flush=1, id_ex_bubble=1; cnt decrements each cycle; leave to RUN when cnt reaches 1. dmem_busy still freezes: go to MEM_WAIT and abandon the flush, since the bubbles already inserted suffice. Further branch_taken is ignored because the EX contents are bubbles.
- MEM_WAIT: pc_write=0, if_id_write=0, id_ex_hold=1, ex_mem_hold=1 for as long as dmem_busy=1. On dmem_busy=0 apply the RUN evaluation in that same cycle, so a branch_taken held during the freeze is flushed on the first unfrozen cycle.
- Reset (rst=0 sampled at a rising edge):
  - state -> RUN, cnt -> 0.
  - While rst=0, outputs forced to pc_write=0, if_id_write=0, if_id_flush=1, id_ex_bubble=1, id_ex_hold=0, ex_mem_hold=0, ctrl_state=00.
  - Reset mid-FLUSH or mid-MEM_WAIT abandons the operation with no residual stall.
- id_ex_bubble and id_ex_hold are never both 1; if_id_flush and if_id_write=0 occur together only in reset.

Optional Feature:
- Macro: HAZ_PERF_CNT_EN.
- Defined: adds outputs lu_stall_cnt[15:0], flush_cnt[15:0], mem_wait_cnt[15:0]. Each increments once per cycle in which its stall or flush output is asserted because of that cause. Counters saturate at 16'hFFFF and clear on reset.
- Not defined: ports and logic absent; behaviour otherwise identical.

Test Plan:
- Load-use: id_ex_memread=1, id_ex_rt=5, if_id_rs=5 -> that cycle pc_write=0, if_id_write=0, id_ex_bubble=1, ctrl_state=00; next cycle ctrl_state=01 with default outputs; then RUN.
- Rt and $0 qualification: id_ex_rt=5, if_id_rt=5, if_id_uses_rt=0 -> no stall. id_ex_rt=0 matching if_id_rs=0 -> no stall.
- Branch with FLUSH_CYCLES=2: branch_taken pulse -> if_id_flush=id_ex_bubble=1 for exactly 2 cycles, ctrl_state 00 then 10, then 00.
- Priority: branch_taken=1 together with an lu condition -> flush only, no LU_STALL. dmem_busy=1 for 3 cycles with branch_taken held -> 3 frozen cycles (holds=1, pc_write=0), then a flush on the 4th cycle.
- Reset: rst=0 asserted mid-FLUSH -> next edge ctrl_state=00 with forced reset outputs; after rst=1, default outputs resume the following cycle.
- HAZ_PERF_CNT_EN: 2 load-use stalls, 1 branch, 3 busy cycles -> lu_stall_cnt=2, flush_cnt=2, mem_wait_cnt=3.
